udma_sdio_txn_ctrl: RTL and testbench

- Transaction sequencer for the uDMA SDIO peripheral, between the register interface and the command/data engines.
- On a start pulse it runs, in order: command phase, optional busy wait, optional multi-block data phase.
- It counts blocks, enforces cycle timeouts, and ends with a single end-of-transfer pulse plus a 6-bit status word. That status word is what software reads back in the status register.

---
 rtl/udma_sdio_txn_ctrl_if.sv | 40 ++++
 rtl/udma_sdio_txn_ctrl.sv | 134 +++++++++++++
 tb/tb_udma_sdio_txn_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_sdio_txn_ctrl_if.sv
// Register-side config, command/data engine handshakes and status of the
// SDIO transaction sequencer. slave = sequencer, master = its environment.
interface udma_sdio_txn_ctrl_if #(
  parameter int TO_WIDTH = 16
);
  logic                cfg_start_i;
  logic [2:0]          cfg_rsp_type_i;
  logic                cfg_data_en_i;
  logic                cfg_data_rwn_i;
  logic [7:0]          cfg_data_block_num_i;
  logic [TO_WIDTH-1:0] cfg_timeout_i;
  logic                cmd_start_o;
  logic [2:0]          cmd_rsp_type_o;
  logic                cmd_done_i;
  logic [1:0]          cmd_err_i;
  logic                dat0_busy_i;
  logic                data_blk_start_o;
  logic                data_rwn_o;
  logic                data_blk_done_i;
  logic                data_crc_err_i;
  logic                busy_o;
  logic                eot_o;
  logic [5:0]          status_o;

  modport slave (
    input  cfg_start_i, cfg_rsp_type_i, cfg_data_en_i, cfg_data_rwn_i,
           cfg_data_block_num_i, cfg_timeout_i, cmd_done_i, cmd_err_i,
           dat0_busy_i, data_blk_done_i, data_crc_err_i,
    output cmd_start_o, cmd_rsp_type_o, data_blk_start_o, data_rwn_o,
           busy_o, eot_o, status_o
  );

  modport master (
    output cfg_start_i, cfg_rsp_type_i, cfg_data_en_i, cfg_data_rwn_i,
           cfg_data_block_num_i, cfg_timeout_i, cmd_done_i, cmd_err_i,
           dat0_busy_i, data_blk_done_i, data_crc_err_i,
    input  cmd_start_o, cmd_rsp_type_o, data_blk_start_o, data_rwn_o,
           busy_o, eot_o, status_o
  );
endinterface

// File: rtl/udma_sdio_txn_ctrl.sv
// SDIO transaction sequencer: command, optional busy wait, optional multi-block
// data phase, with per-phase timeouts and a sticky status word ending in one eot pulse.
module udma_sdio_txn_ctrl #(
  parameter int TO_WIDTH = 16
) (
  input logic                 clk_i,
  input logic                 rstn_i,
  udma_sdio_txn_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CMD, BUSYW, DATA, DWAIT, EOT} state_e;

  localparam logic [TO_WIDTH-1:0] TO_ONE = TO_WIDTH'(1);

  state_e              state;
  logic [2:0]          rsp_type;
  logic                data_en;
  logic                rwn;
  logic [7:0]          blk_num;
  logic [7:0]          blk_cnt;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                cmd_start;
  logic                blk_start;
  logic                eot;
  logic [5:0]          status;
  logic                to_hit;

  // cfg_timeout_i is used live, not latched; zero disables both timeouts
  assign to_hit = (bus.cfg_timeout_i != '0) && (to_cnt == bus.cfg_timeout_i);

  assign bus.cmd_start_o      = cmd_start;
  assign bus.cmd_rsp_type_o   = rsp_type;
  assign bus.data_blk_start_o = blk_start;
  assign bus.data_rwn_o       = rwn;
  assign bus.eot_o            = eot;
  assign bus.status_o         = status;
  assign bus.busy_o           = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      rsp_type  <= '0;
      data_en   <= 1'b0;
      rwn       <= 1'b0;
      blk_num   <= '0;
      blk_cnt   <= '0;
      to_cnt    <= '0;
      cmd_start <= 1'b0;
      blk_start <= 1'b0;
      eot       <= 1'b0;
      status    <= '0;
    end else begin
      cmd_start <= 1'b0;
      blk_start <= 1'b0;
      eot       <= 1'b0;
      // any start outside IDLE (EOT included) is dropped and flagged
      if (bus.cfg_start_i && state != IDLE) status[4] <= 1'b1;
      case (state)
        IDLE: if (bus.cfg_start_i) begin
          rsp_type  <= bus.cfg_rsp_type_i;
          data_en   <= bus.cfg_data_en_i;
          rwn       <= bus.cfg_data_rwn_i;
          blk_num   <= bus.cfg_data_block_num_i;
          blk_cnt   <= '0;
          to_cnt    <= '0;
          status    <= '0;
          cmd_start <= 1'b1;
          state     <= CMD;
        end
        CMD: if (bus.cmd_done_i) begin
          if (bus.cmd_err_i != 2'b00) begin
            status[1:0] <= bus.cmd_err_i;
            eot         <= 1'b1;
            state       <= EOT;
          end else if (rsp_type == 3'd2) begin
            to_cnt <= '0;
            state  <= BUSYW;
          end else if (data_en) begin
            blk_start <= 1'b1;
            state     <= DATA;
          end else begin
            eot   <= 1'b1;
            state <= EOT;
          end
        end
        BUSYW: begin
          if (!bus.dat0_busy_i) begin
            if (data_en) begin
              blk_start <= 1'b1;
              state     <= DATA;
            end else begin
              eot   <= 1'b1;
              state <= EOT;
            end
          end else if (to_hit) begin
            status[5] <= 1'b1;
            eot       <= 1'b1;
            state     <= EOT;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
        DATA: begin
          to_cnt <= '0;
          state  <= DWAIT;
        end
        // block completion takes priority over a timeout in the same cycle
        DWAIT: begin
          if (bus.data_blk_done_i) begin
            if (bus.data_crc_err_i) begin
              status[2] <= 1'b1;
              eot       <= 1'b1;
              state     <= EOT;
            end else if (blk_cnt == blk_num) begin
              eot   <= 1'b1;
              state <= EOT;
            end else begin
              blk_cnt   <= blk_cnt + 8'd1;
              blk_start <= 1'b1;
              state     <= DATA;
            end
          end else if (to_hit) begin
            status[3] <= 1'b1;
            eot       <= 1'b1;
            state     <= EOT;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
        EOT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udma_sdio_txn_ctrl.sv
// Randomized scoreboard bench: a phase-timeline model predicts each transfer's
// eot cycle, status and block count; a monitor checks what the sequencer emits.
module tb_udma_sdio_txn_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udma_sdio_txn_ctrl_if #(.TO_WIDTH(16)) bus ();
  udma_sdio_txn_ctrl #(.TO_WIDTH(16)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

  typedef struct {
    int         s;
    int         eot;
    int         nblk;
    logic [5:0] st;
    logic [5:0] st_post;
    logic       rwn;
    logic [2:0] rsp;
  } exp_t;

  exp_t exp_q[$];

  // transaction descriptor shared by driver, model and responder
  logic [2:0] t_rsp;
  logic       t_den, t_rwn;
  logic [1:0] t_err;
  int t_bn, t_to, t_cd, t_bd, t_crc, t_hang, t_ov;
  int t_dd[256];

  int  zero_chk_cyc = 3;
  bit  end_chk = 1'b0;
  bit  mon_done = 1'b0;
  int  n_cmp = 0, n_bad = 0;

  // ---------------- reference model: phase timeline relative to the start cycle
  task automatic model(output int eo, output int nb, output logic [5:0] st);
    int t;
    bit fin;
    st = '0; nb = 0; eo = 0; fin = 1'b0;
    t = t_cd + 2;
    if (t_err != 2'b00) begin
      st[1:0] = t_err; eo = t; fin = 1'b1;
    end else if (t_rsp == 3'd2) begin
      if (t_to != 0 && t_to < t_bd) begin
        st[5] = 1'b1; eo = t + t_to + 1; fin = 1'b1;
      end else t = t + t_bd + 1;
    end
    if (!fin && !t_den) begin eo = t; fin = 1'b1; end
    for (int i = 0; i <= t_bn && !fin; i++) begin
      nb = i + 1;
      if (i == t_hang || (t_to != 0 && t_dd[i] > t_to + 1)) begin
        st[3] = 1'b1; eo = t + t_to + 2; fin = 1'b1;
      end else if (i == t_crc) begin
        st[2] = 1'b1; eo = t + t_dd[i] + 1; fin = 1'b1;
      end else if (i == t_bn) begin
        eo = t + t_dd[i] + 1; fin = 1'b1;
      end else t = t + t_dd[i] + 1;
    end
  endtask

  // ---------------- engine/card responder
  int cmd_done_at = -1, busy_from = -1, busy_to = -1, blk_done_at = -1, blk_seen = 0;
  bit blk_crc = 1'b0;
  initial begin
    bus.cmd_done_i = 1'b0; bus.cmd_err_i = 2'b00; bus.dat0_busy_i = 1'b0;
    bus.data_blk_done_i = 1'b0; bus.data_crc_err_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.cmd_done_i      = (cyc == cmd_done_at);
      bus.cmd_err_i       = (cyc == cmd_done_at) ? t_err : 2'b00;
      bus.dat0_busy_i     = (cyc >= busy_from) && (cyc < busy_to);
      bus.data_blk_done_i = (cyc == blk_done_at);
      bus.data_crc_err_i  = (cyc == blk_done_at) && blk_crc;
      @(negedge clk);
      if (bus.cmd_start_o) begin
        cmd_done_at = cyc + t_cd;
        busy_from   = cyc + t_cd + 1;
        busy_to     = busy_from + t_bd;
        blk_seen    = 0;
        blk_done_at = -1;
      end
      if (bus.data_blk_start_o) begin
        if (blk_seen < 256 && blk_seen != t_hang) blk_done_at = cyc + t_dd[blk_seen];
        else blk_done_at = -1;
        blk_crc  = (blk_seen == t_crc);
        blk_seen = blk_seen + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard
  int         rd_idx = 0, blk_m = 0;
  bit         post_pending = 1'b0;
  logic [5:0] post_st = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc == zero_chk_cyc)
      chk("reset_outputs", {bus.cmd_start_o, bus.cmd_rsp_type_o, bus.data_blk_start_o,
                            bus.data_rwn_o, bus.busy_o, bus.eot_o, bus.status_o}, 0);
    if (bus.cmd_start_o) begin
      blk_m = 0;
      if (rd_idx < exp_q.size()) begin
        chk("cmd_start_cycle", cyc, exp_q[rd_idx].s + 1);
        chk("cmd_rsp_type", bus.cmd_rsp_type_o, exp_q[rd_idx].rsp);
      end
    end
    if (bus.data_blk_start_o) begin
      blk_m++;
      if (rd_idx < exp_q.size()) chk("data_rwn", bus.data_rwn_o, exp_q[rd_idx].rwn);
    end
    if (post_pending) begin
      chk("status_hold", bus.status_o, post_st);
      chk("busy_after_eot", bus.busy_o, 0);
      post_pending = 1'b0;
    end
    if (bus.eot_o) begin
      chk("eot_expected", rd_idx < exp_q.size(), 1);
      if (rd_idx < exp_q.size()) begin
        chk("eot_cycle", cyc, exp_q[rd_idx].eot);
        chk("status_at_eot", bus.status_o, exp_q[rd_idx].st);
        chk("block_starts", blk_m, exp_q[rd_idx].nblk);
        chk("busy_at_eot", bus.busy_o, 1);
        post_st = exp_q[rd_idx].st_post;
        post_pending = 1'b1;
        rd_idx++;
      end
    end
    if (end_chk && !mon_done) begin
      chk("eots_outstanding", exp_q.size() - rd_idx, 0);
      mon_done = 1'b1;
    end
  end

  // ---------------- driver
  task automatic set_txn(input int rsp, input int den, input int rwn, input int bn,
                         input int to, input int cd, input int err, input int bd,
                         input int dd, input int crc, input int hang, input int ov);
    t_rsp = 3'(rsp); t_den = 1'(den); t_rwn = 1'(rwn); t_bn = bn; t_to = to;
    t_cd = cd; t_err = 2'(err); t_bd = bd; t_crc = crc; t_hang = hang; t_ov = ov;
    for (int i = 0; i < 256; i++) t_dd[i] = dd;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic drive_start(output int s);
    @(posedge clk); #1;
    s = cyc;
    bus.cfg_rsp_type_i       = t_rsp;
    bus.cfg_data_en_i        = t_den;
    bus.cfg_data_rwn_i       = t_rwn;
    bus.cfg_data_block_num_i = 8'(t_bn);
    bus.cfg_timeout_i        = 16'(t_to);
    bus.cfg_start_i          = 1'b1;
  endtask

  task automatic scramble_cfg();
    bus.cfg_start_i          = 1'b0;
    bus.cfg_rsp_type_i       = 3'($urandom_range(0, 7));
    bus.cfg_data_en_i        = 1'($urandom_range(0, 1));
    bus.cfg_data_rwn_i       = 1'($urandom_range(0, 1));
    bus.cfg_data_block_num_i = 8'($urandom_range(0, 255));
  endtask

  task automatic run_txn();
    int eo, nb, s, ov;
    logic [5:0] st;
    exp_t it;
    model(eo, nb, st);
    ov = (t_ov == -1) ? (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, eo)) : 0)
       : (t_ov == -2) ? eo : t_ov;
    drive_start(s);
    it.s = s; it.eot = s + eo; it.nblk = nb; it.rwn = t_rwn; it.rsp = t_rsp;
    it.st      = st | ((ov >= 1 && ov < eo) ? 6'h10 : 6'h00);
    it.st_post = it.st | ((ov == eo) ? 6'h10 : 6'h00);
    exp_q.push_back(it);
    @(posedge clk); #1;
    scramble_cfg();
    if (ov > 0) begin
      wait_cyc(s + ov);
      bus.cfg_start_i = 1'b1;
      @(posedge clk); #1;
      bus.cfg_start_i = 1'b0;
    end
    wait_cyc(s + eo + 3);
  endtask

  initial begin
    int s;
    bus.cfg_start_i = 1'b0; bus.cfg_rsp_type_i = '0; bus.cfg_data_en_i = 1'b0;
    bus.cfg_data_rwn_i = 1'b0; bus.cfg_data_block_num_i = '0; bus.cfg_timeout_i = '0;
    set_txn(0, 0, 0, 0, 0, 1, 0, 0, 1, -1, -1, 0);
    repeat (4) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    set_txn(1, 0, 0, 0,   0, 10, 0,  0,  1, -1, -1,  0); run_txn(); // no-data command
    set_txn(1, 1, 1, 3,   0,  3, 0,  0, 20, -1, -1,  0); run_txn(); // 4-block read
    set_txn(2, 0, 0, 0, 100,  4, 0, 50,  1, -1, -1,  0); run_txn(); // busy, no timeout
    set_txn(2, 0, 0, 0,  30,  4, 0, 50,  1, -1, -1,  0); run_txn(); // busy timeout
    set_txn(1, 1, 0, 3,   0,  5, 1,  0,  5, -1, -1,  0); run_txn(); // cmd no-rsp
    set_txn(2, 1, 0, 1,   0,  2, 2,  9,  3, -1, -1,  0); run_txn(); // cmd CRC
    set_txn(1, 1, 0, 3,   0,  3, 0,  0,  7,  1, -1,  0); run_txn(); // data CRC on block 2
    set_txn(1, 1, 1, 0,   8,  3, 0,  0,  1, -1,  0,  0); run_txn(); // data timeout
    set_txn(1, 1, 1, 1,   0,  2, 0,  0, 20, -1, -1, 10); run_txn(); // overrun in DWAIT
    set_txn(3, 1, 0, 0,   5,  2, 0,  0,  6, -1, -1,  0); run_txn(); // done == timeout
    set_txn(5, 1, 0, 2,   4,  2, 0,  0,  5, -1, -1,  0); run_txn(); // done == timeout, 3 blocks
    set_txn(1, 1, 1, 255, 0,  2, 0,  0,  1, -1, -1,  0); run_txn(); // 256 blocks
    set_txn(0, 0, 0, 0,   0,  3, 0,  0,  1, -1, -1, -2); run_txn(); // start during EOT
    set_txn(2, 1, 1, 2,  12,  2, 0,  0,  3, -1, -1,  0); run_txn(); // busy already released

    for (int n = 0; n < 40; n++) begin
      t_rsp  = 3'($urandom_range(0, 7));
      t_den  = 1'($urandom_range(0, 1));
      t_rwn  = 1'($urandom_range(0, 1));
      t_bn   = int'($urandom_range(0, 5));
      t_to   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(3, 12));
      t_cd   = int'($urandom_range(1, 6));
      t_err  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t_bd   = int'($urandom_range(0, 15));
      t_crc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, t_bn)) : -1;
      t_hang = (t_to != 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, t_bn)) : -1;
      t_ov   = -1;
      for (int i = 0; i < 256; i++) t_dd[i] = int'($urandom_range(1, 10));
      run_txn();
    end

    // reset in the middle of DWAIT: no scoreboard entry, so any eot is flagged
    set_txn(1, 1, 1, 3, 0, 2, 0, 0, 20, -1, -1, 0);
    drive_start(s);
    @(posedge clk); #1;
    scramble_cfg();
    wait_cyc(s + 10);
    rstn = 1'b0;
    zero_chk_cyc = s + 11;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (80) @(posedge clk);

    #1 end_chk = 1'b1;
    for (int i = 0; i < 10 && !mon_done; i++) @(posedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
